// File: rtl/seq_det_pkg.sv
// Shared types and helpers for the word-to-bit "1011" scan controller.
// Holds the detector state encoding, the controller state encoding and
// the detector next-state function.
package seq_det_pkg;

  // Detector states: sN means the last N input bits match the first N
  // bits of the pattern 1011 (s4 = full match).
  localparam logic [2:0] DET_S0 = 3'd0;
  localparam logic [2:0] DET_S1 = 3'd1;
  localparam logic [2:0] DET_S2 = 3'd2;
  localparam logic [2:0] DET_S3 = 3'd3;
  localparam logic [2:0] DET_S4 = 3'd4;

  typedef enum logic [1:0] {
    CTRL_IDLE  = 2'd0,
    CTRL_SHIFT = 2'd1,
    CTRL_FLUSH = 2'd2,
    CTRL_DONE  = 2'd3
  } ctrl_state_e;

  // Overlapping 1011 transition table; unknown encodings fall back to s0.
  function automatic logic [2:0] det_next(input logic [2:0] cur, input logic bit_in);
    logic [2:0] nxt;
    case (cur)
      DET_S0:  nxt = bit_in ? DET_S1 : DET_S0;
      DET_S1:  nxt = bit_in ? DET_S1 : DET_S2;
      DET_S2:  nxt = bit_in ? DET_S3 : DET_S0;
      DET_S3:  nxt = bit_in ? DET_S4 : DET_S2;
      DET_S4:  nxt = bit_in ? DET_S1 : DET_S2;
      default: nxt = DET_S0;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/seq_scan_ctrl_if.sv
// Word input channel and result channel of the scan controller.
// slave: the controller's view; master: the producer/consumer view.
interface seq_scan_ctrl_if #(
  parameter int WORD_W = 8,
  parameter int CNT_W  = 4
);
  logic              s_valid;
  logic              s_ready;
  logic [WORD_W-1:0] s_data;
  logic              s_clr;
  logic              m_valid;
  logic              m_ready;
  logic [CNT_W-1:0]  m_count;
  logic              m_any;

  modport slave (
    input  s_valid, s_data, s_clr, m_ready,
    output s_ready, m_valid, m_count, m_any
  );

  modport master (
    output s_valid, s_data, s_clr, m_ready,
    input  s_ready, m_valid, m_count, m_any
  );
endinterface

// File: rtl/seq_det_1011_en.sv
// Moore overlapping "1011" detector with enable and synchronous clear.
// out is high only while the detector sits in s4; clear beats enable.
module seq_det_1011_en
  import seq_det_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  input  logic in,
  output logic out
);

  logic [2:0] state_r;
  logic [2:0] next_s;
  logic       out_r;

  // Next detector state for the current input bit.
  always_comb begin
    next_s = det_next(state_r, in);
  end

  // State register; output registered alongside so it tracks s4 exactly.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= DET_S0;
      out_r   <= 1'b0;
    end else if (clr) begin
      state_r <= DET_S0;
      out_r   <= 1'b0;
    end else if (en) begin
      state_r <= next_s;
      out_r   <= (next_s == DET_S4);
    end else begin
      state_r <= state_r;
      out_r   <= out_r;
    end
  end

  assign out = out_r;

endmodule

// File: rtl/seq_scan_ctrl.sv
// Word-level controller: serializes each accepted word MSB first into the
// 1011 detector, counts detections attributed to that word and returns the
// count over a valid/ready result channel. Detector history survives
// across words unless the word arrives with s_clr set.
module seq_scan_ctrl
  import seq_det_pkg::*;
#(
  parameter int WORD_W = 8,
  parameter int CNT_W  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  seq_scan_ctrl_if.slave        bus,
  output logic                  busy
);

  localparam int IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WORD_W - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  ctrl_state_e        state_r;
  logic [WORD_W-1:0]  shift_r;
  logic [IDX_W-1:0]   idx_r;
  logic [CNT_W-1:0]   cnt_r;
  logic               shifted_d_r;
  logic               s_ready_r;
  logic               m_valid_r;
  logic               m_any_r;
  logic               busy_r;

  logic               accept_s;
  logic               det_en_s;
  logic               det_in_s;
  logic               det_clr_s;
  logic               det_out_s;
  logic               hit_s;
  logic [CNT_W-1:0]   cnt_next_s;

  // Handshake and detector drive decoded from the current state.
  always_comb begin
    accept_s  = (state_r == CTRL_IDLE) && s_ready_r && bus.s_valid;
    det_en_s  = (state_r == CTRL_SHIFT);
    det_in_s  = shift_r[WORD_W-1];
    det_clr_s = accept_s && bus.s_clr;
  end

  // A hit only counts when the detector output was produced by a bit of
  // this word, so a held s4 from an earlier word is not counted twice.
  always_comb begin
    hit_s = det_out_s && shifted_d_r;
    if (hit_s && (cnt_r != CNT_MAX)) begin
      cnt_next_s = cnt_r + CNT_W'(1);
    end else begin
      cnt_next_s = cnt_r;
    end
  end

  seq_det_1011_en u_det (
    .clk (clk),
    .rst (rst),
    .en  (det_en_s),
    .clr (det_clr_s),
    .in  (det_in_s),
    .out (det_out_s)
  );

  // Controller FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= CTRL_IDLE;
      shift_r     <= '0;
      idx_r       <= '0;
      cnt_r       <= '0;
      shifted_d_r <= 1'b0;
      s_ready_r   <= 1'b1;
      m_valid_r   <= 1'b0;
      m_any_r     <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      shifted_d_r <= det_en_s;
      cnt_r       <= cnt_next_s;
      m_any_r     <= (cnt_next_s != '0);
      case (state_r)
        CTRL_IDLE: begin
          if (accept_s) begin
            shift_r   <= bus.s_data;
            idx_r     <= '0;
            cnt_r     <= '0;
            m_any_r   <= 1'b0;
            s_ready_r <= 1'b0;
            busy_r    <= 1'b1;
            state_r   <= CTRL_SHIFT;
          end else begin
            state_r   <= CTRL_IDLE;
          end
        end
        CTRL_SHIFT: begin
          shift_r <= {shift_r[WORD_W-2:0], 1'b0};
          idx_r   <= idx_r + IDX_W'(1);
          if (idx_r == IDX_LAST) begin
            state_r <= CTRL_FLUSH;
          end else begin
            state_r <= CTRL_SHIFT;
          end
        end
        CTRL_FLUSH: begin
          // Last bit's Moore output is sampled by the counter this cycle.
          m_valid_r <= 1'b1;
          state_r   <= CTRL_DONE;
        end
        CTRL_DONE: begin
          if (bus.m_ready) begin
            m_valid_r <= 1'b0;
            s_ready_r <= 1'b1;
            busy_r    <= 1'b0;
            state_r   <= CTRL_IDLE;
          end else begin
            state_r   <= CTRL_DONE;
          end
        end
        default: begin
          m_valid_r <= 1'b0;
          s_ready_r <= 1'b1;
          busy_r    <= 1'b0;
          state_r   <= CTRL_IDLE;
        end
      endcase
    end
  end

  assign bus.s_ready = s_ready_r;
  assign bus.m_valid = m_valid_r;
  assign bus.m_count = cnt_r;
  assign bus.m_any   = m_any_r;
  assign busy        = busy_r;

endmodule

// File: tb/tb_seq_scan_ctrl.sv
// Self-checking bench for seq_scan_ctrl: directed scenarios plus random
// words compared against a pattern-counting reference model.
module tb_seq_scan_ctrl;

  localparam int WORD_W = 8;
  localparam int CNT_W  = 4;

  logic clk;
  logic rst;
  logic busy;
  int   cyc;
  int   errors;
  int   checks;

  // Reference model state: bits seen since the last clear (last 3 kept).
  bit   hist_q[$];
  int   exp_cnt;
  int   last_accept;
  int   prev_accept;

  seq_scan_ctrl_if #(.WORD_W(WORD_W), .CNT_W(CNT_W)) bus ();

  seq_scan_ctrl #(.WORD_W(WORD_W), .CNT_W(CNT_W)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .busy (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Count 1011 occurrences ending inside this word, using history since clear.
  function automatic int model_word(input logic [WORD_W-1:0] d, input logic c);
    bit s[$];
    int start;
    int n;
    if (c) hist_q.delete();
    s = hist_q;
    start = s.size();
    for (int i = WORD_W - 1; i >= 0; i--) s.push_back(d[i]);
    n = 0;
    for (int i = start; i < s.size(); i++) begin
      if (i >= 3 && s[i-3] == 1'b1 && s[i-2] == 1'b0 && s[i-1] == 1'b1 && s[i] == 1'b1)
        n++;
    end
    hist_q.delete();
    for (int i = (s.size() > 3 ? s.size() - 3 : 0); i < s.size(); i++) hist_q.push_back(s[i]);
    return (n > (2**CNT_W - 1)) ? (2**CNT_W - 1) : n;
  endfunction

  // Present a word, wait for its result, check latency and count.
  task automatic do_word(input logic [WORD_W-1:0] d, input logic c);
    int n;
    bus.s_data  = d;
    bus.s_clr   = c;
    bus.s_valid = 1'b1;
    n = 0;
    while (!bus.s_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    check("accept_timeout", (n < 50), 1);
    @(posedge clk); #1;
    prev_accept = last_accept;
    last_accept = cyc;
    bus.s_valid = 1'b0;
    bus.s_data  = $urandom_range(0, 255);
    bus.s_clr   = $urandom_range(0, 1);
    exp_cnt = model_word(d, c);
    n = 0;
    while (!bus.m_valid && n < 50) begin
      @(posedge clk); #1; n++;
    end
    check("result_latency", cyc - last_accept, WORD_W + 1);
    check("m_count", bus.m_count, exp_cnt);
    check("m_any", bus.m_any, (exp_cnt != 0));
  endtask

  // Hold the result for a number of cycles, then take it.
  task automatic release_result(input int hold);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check("hold_valid", bus.m_valid, 1);
      check("hold_count", bus.m_count, exp_cnt);
    end
    bus.m_ready = 1'b1;
    @(posedge clk); #1;
    check("rel_valid", bus.m_valid, 0);
    check("rel_ready", bus.s_ready, 1);
    check("rel_busy", busy, 0);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    cyc = 0;
    last_accept = 0;
    prev_accept = 0;
    exp_cnt = 0;
    rst = 1'b1;
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.s_clr   = 1'b0;
    bus.m_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rst_s_ready", bus.s_ready, 1);
    check("rst_m_valid", bus.m_valid, 0);
    check("rst_m_count", bus.m_count, 0);
    check("rst_m_any", bus.m_any, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Single occurrence, then overlapping pair.
    do_word(8'b1011_0000, 1'b1);
    check("word1_count", bus.m_count, 1);
    release_result(0);
    do_word(8'b1011_0110, 1'b1);
    check("word2_count", bus.m_count, 2);
    release_result(0);

    // Cross-word history.
    do_word(8'b0000_0101, 1'b1);
    check("histA_count", bus.m_count, 0);
    release_result(0);
    do_word(8'b1000_0000, 1'b0);
    check("histB_count", bus.m_count, 1);
    release_result(0);
    do_word(8'b1000_0000, 1'b1);
    check("histB_clr_count", bus.m_count, 0);
    release_result(0);

    // Backpressure in DONE with a competing word presented.
    bus.m_ready = 1'b0;
    do_word(8'b1011_1011, 1'b1);
    bus.s_valid = 1'b1;
    bus.s_data  = 8'b1011_0000;
    bus.s_clr   = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp_valid", bus.m_valid, 1);
      check("bp_count", bus.m_count, 2);
      check("bp_any", bus.m_any, 1);
      check("bp_s_ready", bus.s_ready, 0);
    end
    bus.s_valid = 1'b0;
    release_result(0);
    @(posedge clk); #1;
    check("bp_no_accept", busy, 0);

    // Reset during the 4th shift cycle, then no stale history.
    do_word(8'b0000_1011, 1'b1);
    release_result(0);
    bus.s_data  = 8'b1011_1010;
    bus.s_clr   = 1'b0;
    bus.s_valid = 1'b1;
    @(posedge clk); #1;
    bus.s_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    hist_q.delete();
    check("mid_rst_s_ready", bus.s_ready, 1);
    check("mid_rst_m_valid", bus.m_valid, 0);
    check("mid_rst_busy", busy, 0);
    do_word(8'b0000_1011, 1'b0);
    check("post_rst_count", bus.m_count, 1);
    release_result(0);

    // Back-to-back words with m_ready tied high.
    for (int k = 0; k < 3; k++) begin
      do_word(8'b1111_1111, 1'b1);
      if (k > 0) check("b2b_period", last_accept - prev_accept, WORD_W + 3);
      release_result(0);
    end

    // Random words, random clears, random backpressure.
    for (int k = 0; k < 30; k++) begin
      bus.m_ready = 1'b0;
      do_word(WORD_W'($urandom_range(0, 255)), ($urandom_range(0, 3) == 0));
      release_result($urandom_range(0, 3));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
